// File: rtl/layer3_frame_seq.sv
// Frame sequencer for the third conv layer: streams one 5x5 three-channel
// feature map out of memory into the layer, then captures the layer's first
// 1x1 result of the frame, with pause, abort and a watchdog while waiting.
module layer3_frame_seq #(
  parameter int NPIX    = 25,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  output logic               rd_en,
  output logic [4:0]         rd_addr,
  input  logic signed [11:0] rd_data0,
  input  logic signed [11:0] rd_data1,
  input  logic signed [11:0] rd_data2,
  output logic               layer_clr,
  output logic signed [11:0] l_in0,
  output logic signed [11:0] l_in1,
  output logic signed [11:0] l_in2,
  output logic               l_valid,
  input  logic signed [11:0] l_out0,
  input  logic signed [11:0] l_out1,
  input  logic signed [11:0] l_out2,
  input  logic               l_valid_out,
  output logic signed [11:0] res0,
  output logic signed [11:0] res1,
  output logic signed [11:0] res2,
  output logic               busy,
  output logic               done,
  output logic               err_timeout
);

  localparam int CW = $clog2(NPIX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] issue_q, issue_d;   // reads issued so far in this frame
  logic [TW-1:0] wait_q, wait_d;     // cycles spent waiting for the result
  logic          err_q, err_d;
  logic          lv_q;               // read data arrives this cycle
  logic          capture;

  // Per-channel views so the datapath can be written once for all channels.
  logic signed [11:0] rd_data_a [3];
  logic signed [11:0] l_out_a   [3];
  logic signed [11:0] hold_q    [3];
  logic signed [11:0] res_q     [3];
  logic signed [11:0] l_in_a    [3];

  assign rd_data_a[0] = rd_data0;
  assign rd_data_a[1] = rd_data1;
  assign rd_data_a[2] = rd_data2;
  assign l_out_a[0]   = l_out0;
  assign l_out_a[1]   = l_out1;
  assign l_out_a[2]   = l_out2;

  // A read goes out on every unpaused STREAM cycle until the frame is fully issued.
  assign rd_en     = (state_q == S_STREAM) && !pause && (issue_q < CW'(NPIX));
  // The address only has meaning while streaming; it parks at 0 elsewhere.
  assign rd_addr   = (state_q == S_STREAM) ? 5'(issue_q) : 5'd0;
  assign layer_clr = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err_timeout = err_q;
  assign l_valid   = lv_q;

  // Next-state logic: abort beats a result strobe, which beats the timeout.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    wait_d  = wait_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue_d = '0;
        wait_d  = '0;
        if (start) begin
          state_d = S_CLEAR;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = abort ? S_IDLE : S_STREAM;
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (l_valid_out) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (rd_en) begin
          issue_d = issue_q + CW'(1);
          if (issue_q == CW'(NPIX - 1)) begin
            state_d = S_WAIT;
            wait_d  = '0;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (l_valid_out) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; an abort also kills the read issued in the abort cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      issue_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      lv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      lv_q    <= rd_en && !abort;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      // Pixel data passes straight through when valid, otherwise the last pixel is held.
      assign l_in_a[gi] = lv_q ? rd_data_a[gi] : hold_q[gi];

      // Remember the most recent valid pixel for the hold behaviour.
      always_ff @(posedge clk) begin
        if (rst) begin
          hold_q[gi] <= '0;
        end else if (lv_q) begin
          hold_q[gi] <= rd_data_a[gi];
        end
      end

      // Capture the frame result on the first accepted layer strobe.
      always_ff @(posedge clk) begin
        if (rst) begin
          res_q[gi] <= '0;
        end else if (capture) begin
          res_q[gi] <= l_out_a[gi];
        end
      end
    end
  endgenerate

  assign l_in0 = l_in_a[0];
  assign l_in1 = l_in_a[1];
  assign l_in2 = l_in_a[2];
  assign res0  = res_q[0];
  assign res1  = res_q[1];
  assign res2  = res_q[2];

endmodule

// File: tb/tb_layer3_frame_seq.sv
// Bench for layer3_frame_seq: directed frame scenarios followed by random
// control traffic, all compared cycle by cycle against a frame-level model.
module tb_layer3_frame_seq;

  localparam int NPIX    = 25;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst, start, abort, pause, l_valid_out;
  logic rd_en, layer_clr, l_valid, busy, done, err_timeout;
  logic [4:0] rd_addr;
  logic signed [11:0] rd_data0, rd_data1, rd_data2;
  logic signed [11:0] l_in0, l_in1, l_in2;
  logic signed [11:0] l_out0, l_out1, l_out2;
  logic signed [11:0] res0, res1, res2;

  always #5 clk = ~clk;

  layer3_frame_seq #(.NPIX(NPIX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .layer_clr(layer_clr),
    .l_in0(l_in0), .l_in1(l_in1), .l_in2(l_in2), .l_valid(l_valid),
    .l_out0(l_out0), .l_out1(l_out1), .l_out2(l_out2), .l_valid_out(l_valid_out),
    .res0(res0), .res1(res1), .res2(res2),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Feature-map memory seen by the DUT, and the bench's record of the last read.
  logic signed [11:0] mem [3][32];
  bit       mem_pend = 1'b0;
  int       mem_addr = 0;

  // Frame-level reference model.
  typedef enum {PH_IDLE, PH_CLEAR, PH_STREAM, PH_WAIT, PH_DONE} phase_t;
  phase_t m_phase   = PH_IDLE;
  int     m_issued  = 0;   // pixels requested this frame
  int     m_waited  = 0;   // cycles spent waiting after the last pixel
  bit     m_err     = 1'b0;
  bit     m_lv      = 1'b0;
  int     m_lv_addr = 0;
  bit     m_known   = 1'b0;
  logic signed [11:0] m_res  [3] = '{default: '0};
  logic signed [11:0] m_hold [3] = '{default: '0};

  // Observed event counts used by the directed scenarios.
  int lv_cnt   = 0;
  int done_cnt = 0;
  int clr_cnt  = 0;
  bit err_prev = 1'b0;

  // One clock cycle: apply inputs, check outputs on the falling edge, advance the model.
  task automatic cyc(input bit r, input bit s, input bit a, input bit p, input bit v,
                     input logic signed [11:0] o0, input logic signed [11:0] o1,
                     input logic signed [11:0] o2);
    bit   e_rd_en;
    int   e_addr;
    logic signed [11:0] e_lin [3];
    @(posedge clk);
    #1;
    if (mem_pend) begin
      rd_data0 = mem[0][mem_addr];
      rd_data1 = mem[1][mem_addr];
      rd_data2 = mem[2][mem_addr];
    end else begin
      rd_data0 = 12'($urandom);
      rd_data1 = 12'($urandom);
      rd_data2 = 12'($urandom);
    end
    rst = r; start = s; abort = a; pause = p; l_valid_out = v;
    l_out0 = o0; l_out1 = o1; l_out2 = o2;
    @(negedge clk);

    e_rd_en = (m_phase == PH_STREAM) && !p && (m_issued < NPIX);
    e_addr  = (m_phase == PH_STREAM) ? m_issued : 0;
    for (int c = 0; c < 3; c++) e_lin[c] = m_lv ? mem[c][m_lv_addr] : m_hold[c];

    if (m_known) begin
      check("rd_en", int'(rd_en), int'(e_rd_en));
      check("rd_addr", int'(rd_addr), e_addr);
      check("layer_clr", int'(layer_clr), int'(m_phase == PH_CLEAR));
      check("busy", int'(busy), int'(m_phase != PH_IDLE));
      check("done", int'(done), int'(m_phase == PH_DONE));
      check("err_timeout", int'(err_timeout), int'(m_err));
      check("l_valid", int'(l_valid), int'(m_lv));
      check("l_in0", int'(l_in0), int'(e_lin[0]));
      check("l_in1", int'(l_in1), int'(e_lin[1]));
      check("l_in2", int'(l_in2), int'(e_lin[2]));
      check("res0", int'(res0), int'(m_res[0]));
      check("res1", int'(res1), int'(m_res[1]));
      check("res2", int'(res2), int'(m_res[2]));
    end

    if (l_valid)   lv_cnt++;
    if (layer_clr) clr_cnt++;
    if (done) begin
      done_cnt++;
      $display("[TB] frame done res=%0d,%0d,%0d", res0, res1, res2);
    end
    if (err_timeout && !err_prev) $display("[TB] frame timed out");
    err_prev = err_timeout;

    mem_pend = rd_en;
    mem_addr = int'(rd_addr);

    if (r) begin
      m_phase = PH_IDLE; m_issued = 0; m_waited = 0; m_err = 1'b0; m_lv = 1'b0;
      m_res  = '{default: '0};
      m_hold = '{default: '0};
      m_known = 1'b1;
    end else begin
      if (m_lv) for (int c = 0; c < 3; c++) m_hold[c] = mem[c][m_lv_addr];
      m_lv      = e_rd_en && !a;
      m_lv_addr = m_issued;
      case (m_phase)
        PH_IDLE:  if (s) begin m_phase = PH_CLEAR; m_err = 1'b0; m_issued = 0; end
        PH_CLEAR: m_phase = a ? PH_IDLE : PH_STREAM;
        PH_STREAM, PH_WAIT: begin
          if (a) m_phase = PH_IDLE;
          else if (v) begin
            m_res[0] = o0; m_res[1] = o1; m_res[2] = o2;
            m_phase = PH_DONE;
          end else if (m_phase == PH_STREAM) begin
            if (e_rd_en) m_issued++;
            if (m_issued == NPIX) begin m_phase = PH_WAIT; m_waited = 0; end
          end else begin
            m_waited++;
            if (m_waited == TIMEOUT) begin m_err = 1'b1; m_phase = PH_IDLE; end
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_counts();
    lv_cnt = 0; done_cnt = 0; clr_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; l_valid_out = 1'b0;
    rd_data0 = '0; rd_data1 = '0; rd_data2 = '0;
    l_out0 = '0; l_out1 = '0; l_out2 = '0;
    for (int c = 0; c < 3; c++)
      for (int ad = 0; ad < 32; ad++) mem[c][ad] = 12'(ad * 3);

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Nominal frame: result arrives a few cycles into WAIT.
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1 + NPIX + 4);
    cyc(0, 0, 0, 0, 1, 5, 6, 7);
    idle(3);
    check("nominal_lvalid_count", lv_cnt, NPIX);
    check("nominal_done_count", done_cnt, 1);
    check("nominal_clr_count", clr_cnt, 1);
    check("nominal_res0", int'(res0), 5);

    // Pause for three cycles right after address 10.
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1 + 11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
    idle(NPIX - 11 + 3);
    cyc(0, 0, 0, 0, 1, -12'sd9, 12'sd100, -12'sd2048);
    idle(2);
    check("pause_lvalid_count", lv_cnt, NPIX);
    check("pause_done_count", done_cnt, 1);

    // Timeout: no result ever arrives.
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1 + NPIX + TIMEOUT + 3);
    check("timeout_flag", int'(err_timeout), 1);
    check("timeout_no_done", done_cnt, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("timeout_cleared_in_clear", int'(err_timeout), 0);
    idle(NPIX + 2);
    cyc(0, 0, 0, 0, 1, 1, 2, 3);
    idle(2);

    // Abort while address 12 is being read.
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1 + 12);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    idle(4);
    check("abort_lvalid_count", lv_cnt, 12);
    check("abort_res0_kept", int'(res0), 1);

    // Start while busy is ignored; abort wins over a same-cycle result.
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(NPIX);
    cyc(0, 0, 1, 0, 1, 44, 55, 66);
    idle(3);
    check("collision_clr_count", clr_cnt, 1);
    check("collision_no_done", done_cnt, 0);
    check("collision_res1_kept", int'(res1), 2);

    // Reset mid-stream, then a full nominal frame.
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(6);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("rst_res2_zero", int'(res2), 0);
    clear_counts();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    idle(1 + NPIX + 2);
    cyc(0, 0, 0, 0, 1, 5, 6, 7);
    idle(2);
    check("rst_restart_lvalid_count", lv_cnt, NPIX);
    check("rst_restart_done_count", done_cnt, 1);

    // Random traffic with signed memory contents.
    for (int c = 0; c < 3; c++)
      for (int ad = 0; ad < 32; ad++) mem[c][ad] = 12'($urandom);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 999) < 3,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 1,
          $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 2,
          12'($urandom), 12'($urandom), 12'($urandom));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer3_frame_seq.md
LAYER3_FRAME_SEQ -- requirements
Module: layer3_frame_seq

Interface
REQ-001 Parameter: NPIX, default 25, number of pixels per 5x5 input frame.
REQ-002 Parameter: TIMEOUT, default 64, maximum cycles in WAIT before an error is flagged.
REQ-003 Reset is synchronous and active-high; one clock domain.
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  frame request, sampled only in IDLE.
REQ-007 abort  in  1  cancel the current frame.
REQ-008 pause  in  1  when high, suppresses new memory reads in STREAM.
REQ-009 rd_en  out  1  feature-map memory read strobe.
REQ-010 rd_addr  out  5  pixel address, 0..NPIX-1, raster order.
REQ-011 rd_data0/1/2  in  12 each, signed  channel data, valid exactly 1 cycle after rd_en.
REQ-012 layer_clr  out  1  one-cycle clear pulse to the conv layer (line buffers and counters).
REQ-013 l_in0/1/2  out  12 each, signed  pixel data to the conv layer.
REQ-014 l_valid  out  1  pixel strobe to the conv layer.
REQ-015 l_out0/1/2  in  12 each, signed  conv layer 1x1 results.
REQ-016 l_valid_out  in  1  conv layer result strobe.
REQ-017 res0/1/2  out  12 each, signed  captured frame results.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 done  out  1  one-cycle pulse when res0..2 update.
REQ-020 err_timeout  out  1  sticky flag, cleared only by the next accepted start or by rst.

Function
REQ-021 States are IDLE, CLEAR, STREAM, WAIT and DONE; encoding is free.
REQ-022 IDLE with start=1 -> CLEAR; start is ignored in every other state.
REQ-023 CLEAR lasts exactly 1 cycle with layer_clr=1, err_timeout cleared and rd_addr=0, then -> STREAM.
REQ-024 STREAM: on each cycle with pause=0 and issue count < NPIX, rd_en=1 with rd_addr = issue count, then the count increments; pause=1 -> rd_en=0 and the address is held.
REQ-025 l_valid equals rd_en delayed 1 cycle; l_in0..2 equal rd_data0..2 in that same cycle; l_valid=0 -> l_in hold last value.
REQ-026 STREAM -> WAIT in the cycle after the NPIX-th rd_en; exactly NPIX l_valid pulses occur per frame.
REQ-027 l_valid_out=1 in STREAM or WAIT -> capture l_out0..2 into res0..2, then -> DONE next cycle; the first result per frame wins and later strobes are ignored.
REQ-028 WAIT: a cycle counter starts at 0 on entry; reaching TIMEOUT without l_valid_out -> err_timeout=1, res unchanged, no done pulse, -> IDLE.
REQ-029 DONE lasts 1 cycle with done=1, then -> IDLE; the earliest restart accepts start in the following IDLE cycle.
REQ-030 abort=1 in any non-IDLE state -> IDLE next cycle; rd_en and l_valid are 0 from that next cycle; any in-flight read data is discarded; res and err_timeout are unchanged.
REQ-031 abort takes priority over l_valid_out, timeout and normal transitions in the same cycle.
REQ-032 l_valid_out in IDLE or CLEAR is ignored.
REQ-033 Minimum frame latency with no pause is 1 (CLEAR) + NPIX (reads) + 1 (data) cycles, plus the layer latency, to the l_valid_out capture.

Reset
REQ-034 rst=1 -> state IDLE; all outputs 0 (rd_en, rd_addr, layer_clr, l_in0..2, l_valid, res0..2, busy, done, err_timeout); all counters 0.
REQ-035 rst mid-frame behaves the same as REQ-034 on the next edge; the pending l_valid is dropped.

Verification
REQ-036 Nominal: start pulse with memory holding addr*3 on all channels -> layer_clr 1 cycle, rd_addr 0..24 contiguous, 25 l_valid with l_in0 = 0,3,..,72; l_valid_out with l_out = 5,6,7 -> res = 5,6,7 and done 1 cycle later.
REQ-037 Pause: pause high for 3 cycles after addr 10 -> no reads for 3 cycles, addr 11 issued next, total still exactly 25 l_valid.
REQ-038 Timeout: no l_valid_out for 64 cycles in WAIT -> err_timeout=1, done stays 0, busy=0; the next start clears err_timeout in CLEAR.
REQ-039 Abort: abort at addr 12 -> rd_en=0 next cycle, busy=0, no further l_valid, res retains its prior value.
REQ-040 Collision: abort and l_valid_out in the same cycle -> IDLE, res unchanged, no done; start while busy -> ignored, no second layer_clr.
REQ-041 Reset: rst asserted in STREAM -> all outputs 0 next cycle; a subsequent start runs a full nominal frame.
